// File: rtl/synth_bus_pkg.sv
// Package: synth_bus_pkg
// Shared constants for the synth bus-slave register file.
//   - Bus widths.
//   - Register offsets of the slave map.
//   - Control register bit positions.
//   - Waveform select encodings driven on WaveType.
package synth_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Register offsets relative to BASE_ADDR
  localparam logic [ADDR_W-1:0] REG_ID       = 16'd0;
  localparam logic [ADDR_W-1:0] REG_PITCH_LO = 16'd1;
  localparam logic [ADDR_W-1:0] REG_PITCH_HI = 16'd2;
  localparam logic [ADDR_W-1:0] REG_CTRL     = 16'd3;
  localparam logic [ADDR_W-1:0] REG_VOL      = 16'd4;

  // Control register layout; bits [6:2] are reserved and read as zero
  localparam int CTRL_EN_BIT   = 7;
  localparam int CTRL_WAVE_LSB = 0;
  localparam int WAVE_W        = 2;

  typedef enum logic [WAVE_W-1:0] {
    WAVE_SINE     = 2'b00,
    WAVE_SQUARE   = 2'b01,
    WAVE_SAW      = 2'b10,
    WAVE_TRIANGLE = 2'b11
  } wave_t;

endpackage

// File: rtl/synth_bus_sync.sv
// Module: synth_bus_sync
// Brings the asynchronous bus write strobe into the clk domain and produces a
// one-cycle pulse for each rising edge.
// Ports:
//   clk        in  1  system clock
//   srst       in  1  synchronous active-high reset
//   async_in   in  1  asynchronous strobe input
//   rise_pulse out 1  one-cycle pulse after a synchronized 0->1 transition
// All three flops reset to 1: a strobe that is already high when reset
// releases looks like a steady high level, never like a fresh edge. Falling
// edges produce nothing.
module synth_bus_sync (
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic rise_pulse
);

  // [0],[1] = two-stage synchronizer, [2] = edge-detect history flop
  logic [2:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], async_in};
    end
  end

  assign rise_pulse = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/synth_bus_regs.sv
// Module: synth_bus_regs
// Bus-slave register file feeding the synth oscillator/waveform path. Writes
// from the asynchronous external bus are captured into the Clock domain on the
// rising edge of BusClock and land 3 Clock edges after that rise.
// Ports:
//   Clock         in    1   system clock
//   Reset         in    1   synchronous active-high reset
//   BusAddress    in    16  bus address (async, held stable by the master)
//   BusData       inout 8   bus data (master drives during writes)
//   BusReadWrite  in    1   1 = master write, 0 = master read
//   BusClock      in    1   asynchronous write strobe, rising edge commits
//   Pitch         out   16  oscillator phase increment
//   WaveType      out   2   waveform select
//   Volume        out   8   output amplitude scale
//   Enable        out   1   oscillator run enable
//   WriteStrobe   out   1   one-Clock pulse per accepted write
// Build option: define SYNTH_BUS_READBACK_EN to drive registered readback data
// onto BusData during reads of offsets 0-4. Without it BusData is never driven.
module synth_bus_regs
  import synth_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter logic [DATA_W-1:0] ID_VALUE  = 8'hA5,
  parameter logic [DATA_W-1:0] VOL_RESET = 8'hFF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] BusAddress,
  inout  wire  [DATA_W-1:0] BusData,
  input  logic              BusReadWrite,
  input  logic              BusClock,
  output logic [15:0]       Pitch,
  output logic [WAVE_W-1:0] WaveType,
  output logic [DATA_W-1:0] Volume,
  output logic              Enable,
  output logic              WriteStrobe
);

  logic              bus_rise;
  logic [ADDR_W-1:0] offset;
  logic              mapped;
  logic              wr_fire;

  logic [15:0]       pitch_reg;
  logic [DATA_W-1:0] pitch_lo_reg;
  wave_t             wave_reg;
  logic [DATA_W-1:0] vol_reg;
  logic              en_reg;
  logic              strobe_reg;

  synth_bus_sync u_sync (
    .clk        (Clock),
    .srst       (Reset),
    .async_in   (BusClock),
    .rise_pulse (bus_rise)
  );

  // Wrapping subtraction: addresses below BASE_ADDR become large and miss.
  assign offset  = BusAddress - BASE_ADDR;
  assign mapped  = (offset <= REG_VOL);
  assign wr_fire = bus_rise & BusReadWrite;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pitch_reg    <= '0;
      pitch_lo_reg <= '0;
      wave_reg     <= WAVE_SINE;
      vol_reg      <= VOL_RESET;
      en_reg       <= 1'b0;
      strobe_reg   <= 1'b0;
    end else begin
      // ID is read-only, so a write there is not an accepted write
      strobe_reg <= wr_fire & mapped & (offset != REG_ID);
      if (wr_fire) begin
        case (offset)
          REG_PITCH_LO: pitch_lo_reg <= BusData;
          // Hi byte and staged lo byte commit together so the oscillator
          // never sees a half-updated increment.
          REG_PITCH_HI: pitch_reg <= {BusData, pitch_lo_reg};
          REG_CTRL: begin
            en_reg   <= BusData[CTRL_EN_BIT];
            wave_reg <= wave_t'(BusData[CTRL_WAVE_LSB +: WAVE_W]);
          end
          REG_VOL: vol_reg <= BusData;
          default: ;
        endcase
      end
    end
  end

  assign Pitch       = pitch_reg;
  assign WaveType    = wave_reg;
  assign Volume      = vol_reg;
  assign Enable      = en_reg;
  assign WriteStrobe = strobe_reg;

`ifdef SYNTH_BUS_READBACK_EN
  logic              rd_oe_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] rd_data_next;

  // Offset 1 reads the committed low byte, not the staging register.
  always_comb begin
    rd_data_next = '0;
    case (offset)
      REG_ID:       rd_data_next = ID_VALUE;
      REG_PITCH_LO: rd_data_next = pitch_reg[7:0];
      REG_PITCH_HI: rd_data_next = pitch_reg[15:8];
      REG_CTRL: begin
        rd_data_next[CTRL_EN_BIT]                = en_reg;
        rd_data_next[CTRL_WAVE_LSB +: WAVE_W]    = wave_reg;
      end
      REG_VOL:      rd_data_next = vol_reg;
      default:      rd_data_next = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_oe_reg   <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rd_oe_reg   <= ~BusReadWrite & mapped;
      rd_data_reg <= rd_data_next;
    end
  end

  assign BusData = rd_oe_reg ? rd_data_reg : {DATA_W{1'bz}};
`else
  assign BusData = {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_synth_bus_regs.sv
// Testbench: tb_synth_bus_regs
// Self-checking bench for synth_bus_regs. A behavioural model (register map
// plus a "commit 3 edges after the strobe rise" countdown) is compared with the
// DUT every cycle; directed scenarios add literal expectations, followed by
// randomized writes, reads and mid-transfer resets.
// Whenever the model says the DUT should not drive BusData, the bench drives
// its own value (write data or a random probe), so a DUT that drives when it
// should not corrupts the observed bus value.
module tb_synth_bus_regs;

  localparam logic [15:0] BASE = 16'h0000;
`ifdef SYNTH_BUS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_addr = 16'h0000;
  logic        rw = 1'b1;
  logic        bus_clk = 1'b0;
  logic [7:0]  tb_val = 8'h00;
  wire  [7:0]  bus_data;

  logic [15:0] pitch;
  logic [1:0]  wave;
  logic [7:0]  vol;
  logic        en;
  logic        strobe;

  // model state
  logic [15:0] m_pitch = 16'h0;
  logic [7:0]  m_lo = 8'h0;
  logic [1:0]  m_wave = 2'b0;
  logic [7:0]  m_vol = 8'hFF;
  logic        m_en = 1'b0;
  logic        m_strobe = 1'b0;
  logic [7:0]  m_rdata = 8'h0;
  logic        exp_drive = 1'b0;
  logic        m_prev = 1'b1;
  int          m_cd = 0;
  logic        m_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  assign bus_data = exp_drive ? 8'hzz : tb_val;

  synth_bus_regs dut (
    .Clock        (clk),
    .Reset        (rst),
    .BusAddress   (bus_addr),
    .BusData      (bus_data),
    .BusReadWrite (rw),
    .BusClock     (bus_clk),
    .Pitch        (pitch),
    .WaveType     (wave),
    .Volume       (vol),
    .Enable       (en),
    .WriteStrobe  (strobe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] read_model(input logic [15:0] off, input logic [15:0] p,
                                            input logic e, input logic [1:0] w, input logic [7:0] v);
    if (off == 16'd0) return 8'hA5;
    if (off == 16'd1) return p[7:0];
    if (off == 16'd2) return p[15:8];
    if (off == 16'd3) return {e, 5'b00000, w};
    if (off == 16'd4) return v;
    return 8'h00;
  endfunction

  // Behavioural model: one step per Clock edge.
  always @(posedge clk) begin : model_b
    logic [15:0] off;
    int cd;
    off = bus_addr - BASE;
    if (rst) begin
      m_pitch <= 16'h0; m_lo <= 8'h0; m_wave <= 2'b0; m_vol <= 8'hFF; m_en <= 1'b0;
      m_strobe <= 1'b0; exp_drive <= 1'b0; m_prev <= 1'b1; m_cd <= 0; m_valid <= 1'b1;
    end else begin
      exp_drive <= RB && !rw && (off <= 16'd4);
      m_rdata   <= read_model(off, m_pitch, m_en, m_wave, m_vol);
      m_strobe  <= 1'b0;
      cd = m_cd;
      if (cd == 1 && rw) begin
        // third edge after the strobe rise: the write lands
        m_strobe <= (off >= 16'd1) && (off <= 16'd4);
        if (off == 16'd1) m_lo <= tb_val;
        if (off == 16'd2) m_pitch <= {tb_val, m_lo};
        if (off == 16'd3) begin m_en <= tb_val[7]; m_wave <= tb_val[1:0]; end
        if (off == 16'd4) m_vol <= tb_val;
      end
      if (cd > 0) cd = cd - 1;
      if (bus_clk && !m_prev) cd = 2;
      m_cd   <= cd;
      m_prev <= bus_clk;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pitch", {16'h0, pitch}, {16'h0, m_pitch});
      check("wave", {30'h0, wave}, {30'h0, m_wave});
      check("volume", {24'h0, vol}, {24'h0, m_vol});
      check("enable", {31'h0, en}, {31'h0, m_en});
      check("strobe", {31'h0, strobe}, {31'h0, m_strobe});
      check("busdata", {24'h0, bus_data}, {24'h0, (exp_drive ? m_rdata : tb_val)});
    end
    if (strobe === 1'b1) strobe_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transfer; optional reset pulse starting rst_at edges after the rise.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int rst_at,
                          input int rst_len, output logic [15:0] p2, output logic [15:0] p3);
    rw = 1'b1; bus_addr = a; tb_val = d;
    tick(); tick();
    bus_clk = 1'b1;
    p2 = 16'h0; p3 = 16'h0;
    for (int i = 0; i < 5; i++) begin
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + rst_len) rst = 1'b0;
      tick();
      if (i == 1) p2 = pitch;
      if (i == 2) p3 = pitch;
    end
    rst = 1'b0;
    bus_clk = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    rw = 1'b0; bus_addr = a; tb_val = 8'($urandom);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stim
    int s0;
    logic [15:0] p2, p3;
    // 1: reset with BusClock low
    tick(); tick(); tick();
    check("rst_pitch", {16'h0, pitch}, 32'h0);
    check("rst_wave", {30'h0, wave}, 32'h0);
    check("rst_volume", {24'h0, vol}, 32'hFF);
    check("rst_enable", {31'h0, en}, 32'h0);
    check("rst_strobe", {31'h0, strobe}, 32'h0);
    check("rst_bus_released", {24'h0, bus_data}, {24'h0, tb_val});
    rst = 1'b0;
    s0 = strobe_cnt;
    tick(); tick(); tick(); tick();
    check("no_strobe_after_release", strobe_cnt - s0, 0);

    // 2: staged pitch then atomic commit
    s0 = strobe_cnt;
    do_write(16'h0001, 8'h3F, -1, 0, p2, p3);
    check("lo_only_pitch", {16'h0, pitch}, 32'h0);
    check("lo_strobe_count", strobe_cnt - s0, 1);
    do_write(16'h0002, 8'h01, -1, 0, p2, p3);
    check("pitch_before_3rd_edge", {16'h0, p2}, 32'h0);
    check("pitch_at_3rd_edge", {16'h0, p3}, 32'h013F);
    check("pitch_strobe_count", strobe_cnt - s0, 2);

    // 3: control and volume
    do_write(16'h0003, 8'h82, -1, 0, p2, p3);
    check("ctrl_enable", {31'h0, en}, 32'h1);
    check("ctrl_wave", {30'h0, wave}, 32'h2);
    do_write(16'h0004, 8'h40, -1, 0, p2, p3);
    check("volume_40", {24'h0, vol}, 32'h40);

    // 4: ID and unmapped writes are ignored
    s0 = strobe_cnt;
    do_write(16'h0000, 8'hFF, -1, 0, p2, p3);
    do_write(16'h0009, 8'hFF, -1, 0, p2, p3);
    check("ignored_strobes", strobe_cnt - s0, 0);
    check("ignored_pitch", {16'h0, pitch}, 32'h013F);
    check("ignored_volume", {24'h0, vol}, 32'h40);

    // 6: readback (or permanent release without the option)
    do_read(16'h0002, 2);
    if (RB) check("read_pitch_hi", {24'h0, bus_data}, 32'h01);
    else    check("read_released", {24'h0, bus_data}, {24'h0, tb_val});
    do_read(16'h0000, 2);
    if (RB) check("read_id", {24'h0, bus_data}, 32'hA5);
    else    check("read_id_released", {24'h0, bus_data}, {24'h0, tb_val});
    rw = 1'b1; tb_val = 8'h5A;
    tick();
    check("release_after_rw", {24'h0, bus_data}, 32'h5A);

    // 5: reset one Clock after the rise, released while BusClock is still high
    s0 = strobe_cnt;
    do_write(16'h0004, 8'h11, 1, 2, p2, p3);
    check("reset_mid_volume", {24'h0, vol}, 32'hFF);
    check("reset_mid_pitch", {16'h0, pitch}, 32'h0);
    check("reset_mid_strobes", strobe_cnt - s0, 0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      if (r < 6)      do_write(a, 8'($urandom), -1, 0, p2, p3);
      else if (r < 8) do_read(a, $urandom_range(1, 4));
      else            do_write(a, 8'($urandom), $urandom_range(0, 2), $urandom_range(1, 2), p2, p3);
    end
    rw = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
